// File: rtl/uart_tx.sv
// uart_tx: 8N1 (optionally 8E1/8O1) UART transmitter with registered serial output
// Ports:
//   clk      - clock, all state changes on rising edge
//   reset    - asynchronous active-high reset
//   tx_start - send request, sampled only while idle
//   data_in  - byte to send, captured on the accepting edge
//   tx_out   - serial line, idles high, driven straight from a flop
//   busy     - high from the accepting edge until the frame completes
//   tx_done  - one-cycle pulse in the first idle cycle after the stop bit
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b0,
  parameter bit          PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  output logic       tx_out,
  output logic       busy,
  output logic       tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t        r_state, w_state_n;
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_data, w_data_n;
  logic          r_tx, w_tx_n;
  logic          r_busy, r_done, w_done_n;
  logic          w_last;
  assign w_last  = r_cnt == LAST;
  assign tx_out  = r_tx;
  assign busy    = r_busy;
  assign tx_done = r_done;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_bit   <= w_bit_n;
      r_data  <= w_data_n;
      r_tx    <= w_tx_n;
      r_busy  <= w_state_n != IDLE;
      r_done  <= w_done_n;
    end
  end
  // Outputs are computed from the next state so the registered line changes
  // exactly on the edge that enters each bit.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = (r_state == IDLE || w_last) ? '0 : r_cnt + 1'b1;
    w_bit_n   = r_bit;
    w_data_n  = r_data;
    w_done_n  = 1'b0;
    case (r_state)
      IDLE: if (tx_start) begin
        w_state_n = START;
        w_data_n  = data_in;
        w_bit_n   = '0;
      end
      START: if (w_last) w_state_n = DATA;
      DATA: if (w_last) begin
        w_bit_n = r_bit + 3'd1;
        if (r_bit == 3'd7) w_state_n = PARITY_EN ? PARITY : STOP;
      end
      PARITY: if (w_last) w_state_n = STOP;
      STOP: if (w_last) begin
        w_state_n = IDLE;
        w_done_n  = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
    w_tx_n = (w_state_n == START)  ? 1'b0 :
             (w_state_n == DATA)   ? w_data_n[w_bit_n] :
             (w_state_n == PARITY) ? (^r_data ^ PARITY_ODD) : 1'b1;
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed scoreboard bench for uart_tx in 8N1, 8E1 and 8O1 builds
module tb_uart_tx;
  localparam int N = 4;
  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [2:0]      start, txo, bsy, dn;
  logic [2:0][7:0] din;
  int              n_vec = 0;
  int              n_bad = 0;
  logic            q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(N)) dut0 (
    .clk(clk), .reset(reset), .tx_start(start[0]), .data_in(din[0]),
    .tx_out(txo[0]), .busy(bsy[0]), .tx_done(dn[0]));
  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
    .clk(clk), .reset(reset), .tx_start(start[1]), .data_in(din[1]),
    .tx_out(txo[1]), .busy(bsy[1]), .tx_done(dn[1]));
  uart_tx #(.CLKS_PER_BIT(N), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
    .clk(clk), .reset(reset), .tx_start(start[2]), .data_in(din[2]),
    .tx_out(txo[2]), .busy(bsy[2]), .tx_done(dn[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic send(input int d, input logic [7:0] data);
    @(negedge clk);
    start[d] = 1'b1;
    din[d]   = data;
    @(posedge clk);
    #1 start[d] = 1'b0;
  endtask

  // Called just after the accepting edge; pmode 0 none, 1 even, 2 odd.
  // inj_cyc >= 1 pulses tx_start with inj_data in that frame cycle.
  task automatic check_frame(input int d, input logic [7:0] data, input int pmode,
                             input int inj_cyc, input logic [7:0] inj_data);
    int   nb;
    logic b;
    b  = 1'b1;
    nb = (pmode != 0) ? 11 : 10;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(data[i]);
    if (pmode != 0) q.push_back((pmode == 2) ? ~^data : ^data);
    q.push_back(1'b1);
    for (int k = 1; k <= nb * N; k++) begin
      @(negedge clk);
      if ((k - 1) % N == 0) b = q.pop_front();
      check("tx_out", txo[d], b);
      check("busy", bsy[d], 1);
      check("tx_done_early", dn[d], 0);
      if (k == inj_cyc) begin
        start[d] = 1'b1;
        din[d]   = inj_data;
      end else if (k == inj_cyc + 1) start[d] = 1'b0;
    end
    @(negedge clk);
    check("tx_done", dn[d], 1);
    check("busy_done", bsy[d], 0);
    check("tx_out_done", txo[d], 1);
    check("queue_empty", q.size(), 0);
  endtask

  initial begin
    start = '0;
    din   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check("rst_tx_out", txo[d], 1);
      check("rst_busy", bsy[d], 0);
      check("rst_tx_done", dn[d], 0);
    end
    reset    = 1'b0;
    start[0] = 1'b1;
    din[0]   = 8'hA5;
    @(posedge clk);
    #1 start[0] = 1'b0;
    din[0] = 8'h00;
    check_frame(0, 8'hA5, 0, -1, 8'h00);
    send(1, 8'h07);
    check_frame(1, 8'h07, 1, -1, 8'h00);
    send(2, 8'h00);
    check_frame(2, 8'h00, 2, -1, 8'h00);
    send(1, 8'h00);
    check_frame(1, 8'h00, 1, -1, 8'h00);
    send(0, 8'hF0);
    check_frame(0, 8'hF0, 0, 4 * N + 2, 8'h3C);
    repeat (3 * N) begin
      @(negedge clk);
      check("no_queue_tx", txo[0], 1);
      check("no_queue_busy", bsy[0], 0);
      check("no_queue_done", dn[0], 0);
    end
    @(negedge clk);
    start[0] = 1'b1;
    din[0]   = 8'h55;
    @(posedge clk);
    #1 din[0] = 8'hFF;
    check_frame(0, 8'h55, 0, -1, 8'h00);
    @(posedge clk);
    #1 start[0] = 1'b0;
    check_frame(0, 8'hFF, 0, -1, 8'h00);
    @(negedge clk);
    check("b2b_idle_busy", bsy[0], 0);
    check("b2b_idle_tx", txo[0], 1);
    send(0, 8'h5A);
    repeat (5 * N + 2) @(negedge clk);
    check("pre_rst_tx_d4", txo[0], 1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_tx", txo[0], 1);
    check("async_rst_busy", bsy[0], 0);
    check("async_rst_done", dn[0], 0);
    repeat (2 * N) begin
      @(negedge clk);
      check("rst_hold_done", dn[0], 0);
      check("rst_hold_tx", txo[0], 1);
    end
    reset    = 1'b0;
    start[0] = 1'b1;
    din[0]   = 8'h81;
    @(posedge clk);
    #1 start[0] = 1'b0;
    check_frame(0, 8'h81, 0, -1, 8'h00);
    repeat (2 * N) begin
      @(negedge clk);
      check("post_idle_done", dn[0], 0);
      check("post_idle_busy", bsy[0], 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per serial bit; legal range 2..65535.
REQ-002 Parameter PARITY_EN, default 0: 1 inserts a parity bit between D7 and the stop bit.
REQ-003 Parameter PARITY_ODD, default 0: with PARITY_EN=1, 0 selects even parity and 1 selects odd parity.
REQ-004 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port tx_start  input  1  request to send data_in; sampled only in IDLE.
REQ-007 Port data_in  input  8  byte to send; captured on the accepting edge.
REQ-008 Port tx_out  output  1  serial line; idles high; registered output.
REQ-009 Port busy  output  1  high from the accepting edge until the frame completes.
REQ-010 Port tx_done  output  1  one-cycle pulse marking frame completion.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY, STOP, encoded in registers.
REQ-012 IDLE: tx_out=1, busy=0; on an edge with tx_start=1, latch data_in into the shift register, clear the bit counter, and go to START.
REQ-013 START: tx_out=0 for exactly CLKS_PER_BIT cycles, starting with the cycle after the accepting edge, then go to DATA.
REQ-014 DATA: send 8 bits LSB first (D0..D7), each held for CLKS_PER_BIT cycles.
REQ-015 DATA exit: after D7, go to PARITY if PARITY_EN=1, otherwise go to STOP.
REQ-016 PARITY: tx_out = XOR of the latched byte, inverted when PARITY_ODD=1; held for CLKS_PER_BIT cycles.
REQ-017 STOP: tx_out=1 for CLKS_PER_BIT cycles, then go to IDLE.
REQ-018 tx_done SHALL be 1 for exactly the one cycle after the final STOP cycle, i.e. the first IDLE cycle; busy=0 in that cycle.
REQ-019 Frame length SHALL be exactly (10+PARITY_EN)*CLKS_PER_BIT cycles from the accepting edge to the tx_done edge.
REQ-020 Baud counter: width ceil(log2(CLKS_PER_BIT)) bits; counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary; no drift across a frame.
REQ-021 Bit counter: 3 bits; wraps to 0 after D7; valid only in DATA.
REQ-022 tx_start while busy=1 SHALL be ignored and SHALL NOT be queued.
REQ-023 data_in changes while busy=1 SHALL NOT affect the frame in progress.
REQ-024 Back-to-back: tx_start=1 in the tx_done cycle SHALL be accepted, and the next start bit SHALL begin on the following cycle with no extra idle bit.
REQ-025 tx_start held high continuously SHALL send back-to-back frames, one per acceptance, each separated only by the single tx_done cycle.
REQ-026 tx_out SHALL be glitch-free, driven directly from a flop.

Reset
REQ-027 While reset=1: state=IDLE, tx_out=1, busy=0, tx_done=0, all counters=0, shift register=0.
REQ-028 Reset asserted mid-frame SHALL force tx_out=1 immediately without waiting for a clock edge; the frame is abandoned and tx_done is not pulsed.
REQ-029 After reset deasserts, the first tx_start SHALL be accepted on the first rising edge at which it is sampled.

Verification
REQ-030 CLKS_PER_BIT=4, PARITY_EN=0, data_in=8'hA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; tx_done 40 cycles after acceptance.
REQ-031 PARITY_EN=1, PARITY_ODD=0, data_in=8'h07 -> parity bit 1, then stop bit; frame is 44 cycles at CLKS_PER_BIT=4.
REQ-032 PARITY_EN=1, PARITY_ODD=1, data_in=8'h00 -> parity bit 1; the same data with PARITY_ODD=0 -> parity bit 0.
REQ-033 tx_start pulsed with data_in=8'h3C mid-frame (during D3) -> ignored; the current frame completes unchanged and no second frame is sent.
REQ-034 tx_start held high with data_in=8'h55 then 8'hFF -> two contiguous frames; stop bit immediately followed by the next start bit one cycle after tx_done.
REQ-035 reset pulsed during D4 -> tx_out=1 asynchronously, busy=0, no tx_done; the next tx_start (8'h81) produces a clean full frame.
